// File: rtl/misr_sig.sv
// misr_sig: parametrised multiple-input signature register with seeded,
// length-limited runs and a registered compare against a golden signature.
module misr_sig #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int               LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] sig,
  output logic             busy,
  output logic             done,
  output logic             match
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             fb;
  logic [WIDTH-1:0] next_sig;
  logic [WIDTH-1:0] start_sig;

  // Signature shifts toward bit 0; the feedback bit enters at the MSB.
  always_comb begin
    fb        = ^(sig & POLY);
    next_sig  = {fb ^ din[WIDTH-1], sig[WIDTH-1:1] ^ din[WIDTH-2:0]};
    start_sig = seed_load ? seed : SEED;
  end

  // start takes priority in every state, so a restart drops that cycle's word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sig   <= SEED;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      match <= 1'b0;
    end else if (start) begin
      sig <= start_sig;
      cnt <= len;
      if (len != '0) begin
        state <= RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
        match <= 1'b0;
      end else begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        match <= (start_sig == golden);
      end
    end else begin
      case (state)
        RUN: begin
          if (din_valid) begin
            sig <= next_sig;
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              match <= (next_sig == golden);
            end
          end
        end
        IDLE, DONE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_misr_sig.sv
// Testbench for misr_sig: directed scenarios plus randomized runs checked
// against an arithmetic signature model.
module tb_misr_sig;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0, seed_load = 1'b0, din_valid = 1'b0;
  logic [7:0]  seed = '0, din = '0, golden = '0, sig;
  logic [15:0] len = '0;
  logic        busy, done, match;

  logic        l_start = 1'b0, l_din_valid = 1'b0;
  logic [3:0]  l_din = '0, l_sig;
  logic [15:0] l_len = '0;
  logic        l_busy, l_done, l_match;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  misr_sig dut (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed(seed),
    .len(len), .din(din), .din_valid(din_valid), .golden(golden),
    .sig(sig), .busy(busy), .done(done), .match(match)
  );

  misr_sig #(.WIDTH(4), .POLY(4'h9), .SEED(4'h0), .LEN_W(16)) legacy (
    .clk(clk), .rst(rst), .start(l_start), .seed_load(1'b0), .seed(4'h0),
    .len(l_len), .din(l_din), .din_valid(l_din_valid), .golden(4'h0),
    .sig(l_sig), .busy(l_busy), .done(l_done), .match(l_match)
  );

  // Signature update as shift-right, XOR in the word, parity of taps at the MSB.
  function automatic logic [7:0] misrModel(input logic [7:0] q, input logic [7:0] d);
    int taps;
    taps = $countones(q & 8'h1D);
    return (q >> 1) ^ d ^ (((taps % 2) == 1) ? 8'h80 : 8'h00);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [7:0] d);
    start     = s;
    din_valid = v;
    din       = d;
    @(posedge clk);
    #1;
    start     = 1'b0;
    din_valid = 1'b0;
  endtask

  logic [3:0] legacyExp [5];
  logic [3:0] legacyIn  [5];
  logic [7:0] words [8];
  logic [7:0] exp, hold, finalSig;
  int         n, gaps;
  logic       wantMatch;

  initial begin
    legacyExp = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7};
    legacyIn  = '{4'h8, 4'h0, 4'h0, 4'h0, 4'h0};

    #2;
    checkOutput("reset_sig", sig, 8'h00);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_match", match, 1'b0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] legacy equivalence");
    l_len = 16'd5;
    l_start = 1'b1;
    @(posedge clk); #1;
    l_start = 1'b0;
    checkOutput("legacy_seed", l_sig, 4'h0);
    checkOutput("legacy_busy", l_busy, 1'b1);
    for (int i = 0; i < 5; i++) begin
      l_din = legacyIn[i];
      l_din_valid = 1'b1;
      @(posedge clk); #1;
      l_din_valid = 1'b0;
      checkOutput($sformatf("legacy_sig%0d", i), l_sig, legacyExp[i]);
      checkOutput($sformatf("legacy_done%0d", i), l_done, (i == 4));
    end

    $display("[TB] zero length");
    seed_load = 1'b1; seed = 8'hA5; golden = 8'hA5; len = 16'd0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("zero_done", done, 1'b1);
    checkOutput("zero_busy", busy, 1'b0);
    checkOutput("zero_sig", sig, 8'hA5);
    checkOutput("zero_match", match, 1'b1);

    $display("[TB] gapped stream");
    seed_load = 1'b0; len = 16'd3;
    finalSig = misrModel(misrModel(misrModel(8'h00, 8'h01), 8'h02), 8'h03);
    golden = finalSig;
    applyStimulus(1'b1, 1'b0, 8'h00);
    exp = 8'h00;
    checkOutput("gap_seed", sig, exp);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i));
      exp = misrModel(exp, 8'(i));
      checkOutput($sformatf("gap_sig%0d", i), sig, exp);
      checkOutput($sformatf("gap_done%0d", i), done, (i == 3));
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          applyStimulus(1'b0, 1'b0, 8'($urandom));
          checkOutput("gap_hold", sig, exp);
          checkOutput("gap_busy", busy, 1'b1);
        end
      end
    end
    checkOutput("gap_match", match, 1'b1);

    $display("[TB] mismatch");
    golden = finalSig ^ 8'h01;
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 1'b1, 8'(i));
    checkOutput("mis_done", done, 1'b1);
    checkOutput("mis_match", match, 1'b0);
    checkOutput("mis_sig", sig, finalSig);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'($urandom));
      checkOutput("mis_frozen", sig, finalSig);
      checkOutput("mis_done_held", done, 1'b1);
    end

    $display("[TB] restart priority");
    len = 16'd4;
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h33);
    applyStimulus(1'b0, 1'b1, 8'h44);
    applyStimulus(1'b1, 1'b1, 8'h5A);
    checkOutput("rs_sig", sig, 8'h00);
    checkOutput("rs_busy", busy, 1'b1);
    checkOutput("rs_done", done, 1'b0);
    len = 16'd1;
    exp = 8'h00;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h10 + i));
      exp = misrModel(exp, 8'(8'h10 + i));
      checkOutput($sformatf("rs_sig%0d", i), sig, exp);
      checkOutput($sformatf("rs_done%0d", i), done, (i == 3));
    end

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 6);
      seed_load = 1'($urandom_range(0, 1));
      seed = 8'($urandom);
      len = 16'(n);
      exp = seed_load ? seed : 8'h00;
      finalSig = exp;
      for (int k = 0; k < n; k++) begin
        words[k] = 8'($urandom);
        finalSig = misrModel(finalSig, words[k]);
      end
      wantMatch = 1'($urandom_range(0, 1));
      golden = wantMatch ? finalSig : (finalSig ^ 8'($urandom_range(1, 255)));
      applyStimulus(1'b1, 1'b0, 8'($urandom));
      checkOutput("rnd_seed", sig, exp);
      for (int k = 0; k < n; k++) begin
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
          applyStimulus(1'b0, 1'b0, 8'($urandom));
          checkOutput("rnd_hold", sig, exp);
        end
        applyStimulus(1'b0, 1'b1, words[k]);
        exp = misrModel(exp, words[k]);
        checkOutput("rnd_sig", sig, exp);
        checkOutput("rnd_done", done, (k == n - 1));
      end
      checkOutput("rnd_match", match, wantMatch);
    end

    $display("[TB] async reset");
    seed_load = 1'b1; seed = 8'h3C; len = 16'd5;
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h77);
    applyStimulus(1'b0, 1'b1, 8'h88);
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_sig", sig, 8'h00);
    checkOutput("ar_busy", busy, 1'b0);
    checkOutput("ar_done", done, 1'b0);
    checkOutput("ar_match", match, 1'b0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    hold = sig;
    checkOutput("ar_idle_hold", hold, 8'h00);
    seed_load = 1'b0; len = 16'd2;
    exp = misrModel(misrModel(8'h00, 8'hC3), 8'h5E);
    golden = exp;
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'hC3);
    checkOutput("ar_run_done0", done, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h5E);
    checkOutput("ar_run_sig", sig, exp);
    checkOutput("ar_run_done", done, 1'b1);
    checkOutput("ar_run_match", match, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
